// File: rtl/pipe_reduct_if.sv
// Streaming handshake bundle for the pipelined word reduction block.
// No storage, no latency of its own.
// Carries valid/ready in both directions and the per-beat op, inv and mask.
interface pipe_reduct_if #(
    parameter int IN   = 4,
    parameter int DATA = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic [IN-1:0][DATA-1:0]  in;
    logic [IN-1:0]            in_mask;
    logic [1:0]               ope;
    logic                     inv;
    logic                     out_valid;
    logic                     out_ready;
    logic [DATA-1:0]          out;
    logic [1:0]               out_ope;

    // Producer/consumer side (drives beats in, accepts results)
    modport master (
        output in_valid, in, in_mask, ope, inv, out_ready,
        input  in_ready, out_valid, out, out_ope
    );

    // Reduction block side
    modport slave (
        input  in_valid, in, in_mask, ope, inv, out_ready,
        output in_ready, out_valid, out, out_ope
    );
endinterface

// File: rtl/pipe_reduct.sv
// Pipelined and/or/xor reduction of IN masked words to one word, binary tree, one register per level.
// Latency L = max(1, clog2(IN)) cycles from accept edge to out visible; one beat per cycle.
// Global stall: every stage holds while out_valid & !out_ready; in_ready = !out_valid | out_ready.
module pipe_reduct #(
    parameter int IN   = 4,
    parameter int DATA = 16
) (
    input  logic         clk,
    input  logic         reset,
    pipe_reduct_if.slave bus
);

    localparam int LOG2_IN = $clog2(IN);
    localparam int EIN     = 1 << LOG2_IN;
    localparam int L       = (LOG2_IN < 1) ? 1 : LOG2_IN;
    // Stage 1 width; IN = 1 still gets one register pairing word 0 with the identity
    localparam int W1      = (EIN > 1) ? EIN / 2 : 1;
    localparam int P       = 2 * W1;

    // Reserved op collapses to zero at every level, so the final word is zero before inversion
    function automatic logic [DATA-1:0] combine(input logic [1:0] op,
                                                input logic [DATA-1:0] a,
                                                input logic [DATA-1:0] b);
        case (op)
            2'd0:    combine = a & b;
            2'd1:    combine = a | b;
            2'd2:    combine = a ^ b;
            default: combine = '0;
        endcase
    endfunction

    logic [P-1:0][DATA-1:0] in_pad;
    logic [P-1:0]           mask_pad;
    logic [DATA-1:0]        ident;
    logic [DATA-1:0]        w  [P];
    logic [DATA-1:0]        s1 [W1];

    logic [DATA-1:0]        dat  [1:L][0:W1-1];
    logic                   vld  [1:L];
    logic [1:0]             opr  [1:L];
    logic                   invr [1:L];
    logic                   adv;

    // Leaf level: padded or masked-off words become the op identity, then pairs are combined
    always_comb begin
        in_pad            = '0;
        in_pad[IN-1:0]    = bus.in;
        mask_pad          = '0;
        mask_pad[IN-1:0]  = bus.in_mask;
        ident             = (bus.ope == 2'd0) ? {DATA{1'b1}} : '0;
        for (int i = 0; i < P; i++) begin
            w[i] = mask_pad[i] ? in_pad[i] : ident;
        end
        for (int i = 0; i < W1; i++) begin
            s1[i] = combine(bus.ope, w[2*i], w[2*i+1]);
        end
    end

    assign adv = !vld[L] || bus.out_ready;

    // Tree registers: all levels advance together on adv so bubbles travel with the data
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= L; k++) begin
                vld[k]  <= 1'b0;
                opr[k]  <= 2'd0;
                invr[k] <= 1'b0;
                for (int j = 0; j < W1; j++) begin
                    dat[k][j] <= '0;
                end
            end
        end else if (adv) begin
            vld[1]  <= bus.in_valid;
            opr[1]  <= bus.ope;
            invr[1] <= bus.inv;
            for (int j = 0; j < W1; j++) begin
                dat[1][j] <= s1[j];
            end
            for (int k = 2; k <= L; k++) begin
                vld[k]  <= vld[k-1];
                opr[k]  <= opr[k-1];
                invr[k] <= invr[k-1];
                for (int j = 0; j < (EIN >> k); j++) begin
                    dat[k][j] <= combine(opr[k-1], dat[k-1][2*j], dat[k-1][2*j+1]);
                end
            end
        end
    end

    assign bus.in_ready  = adv;
    assign bus.out_valid = vld[L];
    assign bus.out       = invr[L] ? ~dat[L][0] : dat[L][0];
    assign bus.out_ope   = opr[L];

endmodule

// File: tb/tb_pipe_reduct.sv
// Bench for pipe_reduct: directed beats on IN=4/5/1 instances, scoreboarded streams on IN=4 and IN=7.
// Expected words come from a sequential fold over the enabled words, not from a tree.
// Outputs are sampled on the falling edge or just after it.
module tb_pipe_reduct;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    pipe_reduct_if #(.IN(4), .DATA(16)) b4 ();
    pipe_reduct_if #(.IN(5), .DATA(8))  b5 ();
    pipe_reduct_if #(.IN(1), .DATA(16)) b1 ();
    pipe_reduct_if #(.IN(7), .DATA(16)) b7 ();

    pipe_reduct #(.IN(4), .DATA(16)) u4 (.clk(clk), .reset(reset), .bus(b4));
    pipe_reduct #(.IN(5), .DATA(8))  u5 (.clk(clk), .reset(reset), .bus(b5));
    pipe_reduct #(.IN(1), .DATA(16)) u1 (.clk(clk), .reset(reset), .bus(b1));
    pipe_reduct #(.IN(7), .DATA(16)) u7 (.clk(clk), .reset(reset), .bus(b7));

    // Reference: fold the enabled words left to right starting from the op identity
    function automatic logic [15:0] model(input int n, input int dw, input logic [6:0][15:0] w,
                                          input logic [6:0] m, input logic [1:0] op, input logic iv);
        logic [15:0] acc;
        acc = (op == 2'd0) ? 16'hFFFF : 16'h0000;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                case (op)
                    2'd0:    acc = acc & w[i];
                    2'd1:    acc = acc | w[i];
                    2'd2:    acc = acc ^ w[i];
                    default: acc = 16'h0000;
                endcase
            end
        end
        if (op == 2'd3) acc = 16'h0000;
        if (iv) acc = ~acc;
        return acc & (16'hFFFF >> (16 - dw));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", b4.out_valid); end
        n_tests++; if (b4.out !== 16'h0000) begin n_fail++; $display("FAIL reset_out got %h want 0000", b4.out); end
        n_tests++; if (b4.out_ope !== 2'd0) begin n_fail++; $display("FAIL reset_out_ope got %0d want 0", b4.out_ope); end
        n_tests++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", b4.in_ready); end
        n_tests++; if (b7.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid7 got %b want 0", b7.out_valid); end
    endtask

    task automatic test_or();
        b4.in = {16'h1000, 16'h0100, 16'h0010, 16'h0001};
        b4.in_mask = 4'b1111; b4.ope = 2'd1; b4.inv = 1'b0; b4.out_ready = 1'b1; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL or_early_valid got %b want 0", b4.out_valid); end
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b1) begin n_fail++; $display("FAIL or_valid got %b want 1", b4.out_valid); end
        n_tests++; if (b4.out !== 16'h1111) begin n_fail++; $display("FAIL or_out got %h want 1111", b4.out); end
        n_tests++; if (b4.out_ope !== 2'd1) begin n_fail++; $display("FAIL or_ope got %0d want 1", b4.out_ope); end
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL or_dup_valid got %b want 0", b4.out_valid); end
    endtask

    task automatic test_and_pad();
        b5.in = {8'h0F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        b5.in_mask = 5'b11111; b5.ope = 2'd0; b5.inv = 1'b0; b5.out_ready = 1'b1; b5.in_valid = 1'b1;
        @(negedge clk);
        b5.inv = 1'b1;
        @(negedge clk);
        b5.in_valid = 1'b0;
        n_tests++; if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL and_early_valid got %b want 0", b5.out_valid); end
        @(negedge clk);
        n_tests++; if (b5.out_valid !== 1'b1) begin n_fail++; $display("FAIL and_valid got %b want 1", b5.out_valid); end
        n_tests++; if (b5.out !== 8'h0F) begin n_fail++; $display("FAIL and_pad_out got %h want 0f", b5.out); end
        @(negedge clk);
        n_tests++; if (b5.out_valid !== 1'b1) begin n_fail++; $display("FAIL nand_valid got %b want 1", b5.out_valid); end
        n_tests++; if (b5.out !== 8'hF0) begin n_fail++; $display("FAIL nand_pad_out got %h want f0", b5.out); end
        @(negedge clk);
        n_tests++; if (b5.out_valid !== 1'b0) begin n_fail++; $display("FAIL and_dup_valid got %b want 0", b5.out_valid); end
    endtask

    task automatic test_xor_mask();
        b4.in = {16'h00FF, 16'h000F, 16'h00FF, 16'h00AA};
        b4.in_mask = 4'b0101; b4.ope = 2'd2; b4.inv = 1'b0; b4.out_ready = 1'b1; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_mask = 4'b0000; b4.ope = 2'd0;
        @(negedge clk);
        b4.in_valid = 1'b0;
        n_tests++; if (b4.out_valid !== 1'b1 || b4.out !== 16'h00A5) begin n_fail++; $display("FAIL xor_mask_out got v=%b %h want v=1 00a5", b4.out_valid, b4.out); end
        n_tests++; if (b4.out_ope !== 2'd2) begin n_fail++; $display("FAIL xor_mask_ope got %0d want 2", b4.out_ope); end
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b1 || b4.out !== 16'hFFFF) begin n_fail++; $display("FAIL and_nomask_out got v=%b %h want v=1 ffff", b4.out_valid, b4.out); end
        n_tests++; if (b4.out_ope !== 2'd0) begin n_fail++; $display("FAIL and_nomask_ope got %0d want 0", b4.out_ope); end
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL xor_dup_valid got %b want 0", b4.out_valid); end
    endtask

    task automatic test_in1();
        b1.in = 16'h1234; b1.in_mask = 1'b1; b1.ope = 2'd0; b1.inv = 1'b1; b1.out_ready = 1'b1; b1.in_valid = 1'b1;
        @(negedge clk);
        n_tests++; if (b1.out_valid !== 1'b1 || b1.out !== 16'hEDCB) begin n_fail++; $display("FAIL in1_out got v=%b %h want v=1 edcb", b1.out_valid, b1.out); end
        b1.ope = 2'd3;
        @(negedge clk);
        b1.in_valid = 1'b0;
        n_tests++; if (b1.out_valid !== 1'b1 || b1.out !== 16'hFFFF) begin n_fail++; $display("FAIL in1_reserved_inv got v=%b %h want v=1 ffff", b1.out_valid, b1.out); end
        n_tests++; if (b1.out_ope !== 2'd3) begin n_fail++; $display("FAIL in1_ope got %0d want 3", b1.out_ope); end
        @(negedge clk);
        n_tests++; if (b1.out_valid !== 1'b0) begin n_fail++; $display("FAIL in1_dup_valid got %b want 0", b1.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [15:0]      exp_q[$];
        logic [1:0]       ope_q[$];
        logic [6:0][15:0] w7;
        logic [1:0]       ops [4];
        logic [3:0]       mk;
        logic             iv;
        int               sent, got, first_out;
        bit               need_new, saw_stall;
        ops = '{2'd1, 2'd0, 2'd2, 2'd3};
        sent = 0; got = 0; first_out = -1; need_new = 1'b1; saw_stall = 1'b0; w7 = '0; mk = '0; iv = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            if (need_new && sent < 4) begin
                for (int i = 0; i < 4; i++) w7[i] = 16'($urandom());
                mk = 4'($urandom()); iv = 1'($urandom());
                b4.in = w7[3:0]; b4.in_mask = mk; b4.ope = ops[sent]; b4.inv = iv;
                need_new = 1'b0;
            end
            b4.in_valid  = (sent < 4);
            b4.out_ready = !(first_out >= 0 && cyc > first_out && cyc <= first_out + 3);
            #1;
            n_tests++;
            if (b4.in_ready !== (!b4.out_valid || b4.out_ready)) begin
                n_fail++; $display("FAIL b2b_in_ready cyc %0d got %b want %b", cyc, b4.in_ready, !b4.out_valid || b4.out_ready);
            end
            if (!b4.in_ready) saw_stall = 1'b1;
            if (b4.out_valid) begin
                if (first_out < 0) first_out = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_spurious cyc %0d got %h want no beat", cyc, b4.out);
                end else if (b4.out !== exp_q[0] || b4.out_ope !== ope_q[0]) begin
                    n_fail++; $display("FAIL b2b_out cyc %0d got %h/%0d want %h/%0d", cyc, b4.out, b4.out_ope, exp_q[0], ope_q[0]);
                end
                if (b4.out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front()); void'(ope_q.pop_front()); got++;
                end
            end
            if (b4.in_valid && b4.in_ready) begin
                exp_q.push_back(model(4, 16, w7, {3'b000, mk}, ops[sent], iv));
                ope_q.push_back(ops[sent]);
                sent++; need_new = 1'b1;
            end
            @(negedge clk);
        end
        b4.in_valid = 1'b0; b4.out_ready = 1'b1;
        n_tests++; if (got !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", got); end
        n_tests++; if (saw_stall !== 1'b1) begin n_fail++; $display("FAIL b2b_stall got %b want 1", saw_stall); end
    endtask

    task automatic test_reset_mid();
        logic [6:0][15:0] w7;
        logic             iv;
        logic [15:0]      exp;
        w7 = '0;
        for (int i = 0; i < 4; i++) w7[i] = 16'($urandom());
        b4.in = w7[3:0]; b4.in_mask = 4'b1111; b4.ope = 2'd1; b4.inv = 1'b0;
        b4.out_ready = 1'b0; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.ope = 2'd2;
        @(negedge clk);
        b4.in_valid = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b want 0", b4.out_valid); end
        n_tests++; if (b4.out !== 16'h0000) begin n_fail++; $display("FAIL rmid_out got %h want 0000", b4.out); end
        n_tests++; if (b4.out_ope !== 2'd0) begin n_fail++; $display("FAIL rmid_ope got %0d want 0", b4.out_ope); end
        b4.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_tests++; if (b4.in_ready !== 1'b1) begin n_fail++; $display("FAIL rmid_in_ready got %b want 1", b4.in_ready); end
            end
            n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_stale cyc %0d got %b want 0", c, b4.out_valid); end
        end
        for (int i = 0; i < 4; i++) w7[i] = 16'($urandom());
        iv = 1'($urandom());
        exp = model(4, 16, w7, 7'b0001111, 2'd2, iv);
        b4.in = w7[3:0]; b4.in_mask = 4'b1111; b4.ope = 2'd2; b4.inv = iv; b4.in_valid = 1'b1;
        @(negedge clk);
        b4.in_valid = 1'b0;
        n_tests++; if (b4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_new_early got %b want 0", b4.out_valid); end
        @(negedge clk);
        n_tests++; if (b4.out_valid !== 1'b1 || b4.out !== exp) begin n_fail++; $display("FAIL rmid_new_out got v=%b %h want v=1 %h", b4.out_valid, b4.out, exp); end
        @(negedge clk);
    endtask

    task automatic test_stress();
        localparam int NB = 200;
        logic [15:0]      exp_q[$];
        logic [1:0]       ope_q[$];
        logic [6:0][15:0] w7;
        logic [6:0]       mk;
        logic [1:0]       op;
        logic             iv;
        bit               pending;
        int               sent, got;
        sent = 0; got = 0; pending = 1'b0; w7 = '0; mk = '0; op = '0; iv = 1'b0;
        for (int cyc = 0; cyc < 3000 && got < NB; cyc++) begin
            if (!pending && sent < NB) begin
                pending = ($urandom_range(0, 9) < 7);
                if (pending) begin
                    for (int i = 0; i < 7; i++) w7[i] = 16'($urandom());
                    mk = 7'($urandom()); op = 2'($urandom()); iv = 1'($urandom());
                    b7.in = w7; b7.in_mask = mk; b7.ope = op; b7.inv = iv;
                end
            end
            b7.in_valid  = pending;
            b7.out_ready = ($urandom_range(0, 9) < 7);
            #1;
            n_tests++;
            if (b7.in_ready !== (!b7.out_valid || b7.out_ready)) begin
                n_fail++; $display("FAIL stress_in_ready cyc %0d got %b want %b", cyc, b7.in_ready, !b7.out_valid || b7.out_ready);
            end
            if (b7.out_valid) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL stress_spurious cyc %0d got %h want no beat", cyc, b7.out);
                end else if (b7.out !== exp_q[0] || b7.out_ope !== ope_q[0]) begin
                    n_fail++; $display("FAIL stress_out cyc %0d got %h/%0d want %h/%0d", cyc, b7.out, b7.out_ope, exp_q[0], ope_q[0]);
                end
                if (b7.out_ready && exp_q.size() > 0) begin
                    void'(exp_q.pop_front()); void'(ope_q.pop_front()); got++;
                end
            end
            if (b7.in_valid && b7.in_ready) begin
                exp_q.push_back(model(7, 16, w7, mk, op, iv));
                ope_q.push_back(op);
                sent++; pending = 1'b0;
            end
            @(negedge clk);
        end
        b7.in_valid = 1'b0; b7.out_ready = 1'b1;
        n_tests++; if (got !== NB) begin n_fail++; $display("FAIL stress_count got %0d want %0d", got, NB); end
    endtask

    initial begin
        reset = 1'b1;
        b4.in_valid = 1'b0; b4.in = '0; b4.in_mask = '0; b4.ope = '0; b4.inv = 1'b0; b4.out_ready = 1'b1;
        b5.in_valid = 1'b0; b5.in = '0; b5.in_mask = '0; b5.ope = '0; b5.inv = 1'b0; b5.out_ready = 1'b1;
        b1.in_valid = 1'b0; b1.in = '0; b1.in_mask = '0; b1.ope = '0; b1.inv = 1'b0; b1.out_ready = 1'b1;
        b7.in_valid = 1'b0; b7.in = '0; b7.in_mask = '0; b7.ope = '0; b7.inv = 1'b0; b7.out_ready = 1'b1;
        test_reset();
        test_or();
        test_and_pad();
        test_xor_mask();
        test_in1();
        test_back_to_back();
        test_reset_mid();
        test_stress();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pipe_reduct.md
Name: pipe_reduct

Overview:
- Pipelined, back-pressurable successor to the combinational reduction tree.
- Reduces IN words of DATA bits to one word through a binary tree with one register per tree level.
- Operation (and/or/xor, optional inversion) and per-input mask are chosen per beat and travel with the data.
- Sits between streaming producers and consumers, e.g. match-vector merging in CAM/arbiter paths, under a valid/ready handshake.

Parameters:
- IN, 4, number of input words; any value >= 1, need not be a power of two.
- DATA, 16, width of each word.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in  input  IN*DATA  packed input words; word i = in[i].
- in_mask  input  IN  1 = word i takes part in the reduction; 0 = replaced by the identity element.
- ope  input  2  operation: 0 and, 1 or, 2 xor, 3 reserved.
- inv  input  1  1 = invert the final result (nand/nor/xnor).
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out  output  DATA  reduced result.
- out_ope  output  2  ope of the beat on out, for debug and tagging.

Behaviour:
- Internal sizes: LOG2_IN = clog2(IN); EIN = 1<<LOG2_IN; stage count L = max(1, LOG2_IN).
- Stage 1:
  - Apply the mask: masked-off or padded words (index >= IN) become the identity element. The identity is all-ones for and, zero for or/xor, zero for reserved.
  - Combine pairs (2i, 2i+1).
  - Register the results with ope, inv and valid.
- Stage k (2..L): combine pairs of stage k-1 registers and register them.
- Stage L result drives out, inverted if its stored inv = 1.
- IN = 1: single register stage. out = in[0] (or the identity if masked), optionally inverted.
- ope = 3 (reserved): the result is all zeros before inversion, so inv=1 gives all ones. No error flag.
- Latency: a beat accepted at edge t appears on out_valid/out after edge t+L-1, i.e. visible from cycle t+L when out_ready is held high.
- Throughput: one beat per cycle when out_ready = 1.
- Handshake:
  - Global stall: adv = !out_valid | out_ready; in_ready = adv (combinational).
  - When adv = 1, every stage loads from its predecessor, including valid bits, so bubbles propagate.
  - When adv = 0, all stages hold.
  - A beat transfers in when in_valid & in_ready, and out when out_valid & out_ready.
  - in_ready has no combinational dependence on in_valid.
- out, out_ope and out_valid stay stable while out_valid = 1 and out_ready = 0.
- Data registers of invalid stages may load freely. out is only meaningful when out_valid = 1.
- Mixed beats: each beat uses its own ope/inv/in_mask. Consecutive beats with different ops must not interfere.
- All mask bits 0: result is the identity of the op (and -> all ones, or/xor -> 0), then inverted if inv = 1.
- Reset (sync, high):
  - Clears all valid bits, so out_valid = 0, and clears data and ope registers, so out = 0 and out_ope = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards every in-flight beat. No partial beat emerges after reset.
- Simultaneous input and output transfer on a full pipeline is allowed and keeps occupancy at L.

Test Plan:
- IN=4, DATA=16, or, mask=1111, in={0x0001,0x0010,0x0100,0x1000}, out_ready=1 -> out=0x1111 with out_valid two cycles later.
- IN=5, DATA=8, and, mask=11111, all words 0xFF except in[4]=0x0F -> out=0x0F (the padded words must not force 0x00). With inv=1 -> 0xF0.
- IN=4, xor, mask=0101, in={0xAA,0xFF,0x0F,0xFF} -> out=0xA5. With mask=0000 and ope=and -> out=0xFFFF (DATA=16).
- Back-to-back beats or/and/xor/reserved, with out_ready low for 3 cycles after the first output -> in_ready low once full, outputs held stable, all four results in order, no loss or duplication.
- Reset asserted with 2 beats in flight -> out_valid=0, out=0 next cycle. No stale beat ever appears. New beat after reset returns correctly after L cycles.
- IN=1, DATA=16, in=0x1234, inv=1 -> out=0xEDCB after 1 cycle. Random stress IN=7 against a reference model with random valid/ready -> zero mismatches.
